// File: rtl/vga_timing_generator.sv
// VGA raster timing for the Pong display: pixel/line counters, 1-based coordinate decode,
// and a single registered output stage that keeps hsync, vsync and RGB mutually aligned.
module vga_timing_generator #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit SYNC_ACTIVE = 1'b0,
   parameter int RGB_WIDTH   = 4
) (
   input  logic                 CLOCK_25,
   input  logic                 reset,
   input  logic [2:0]           color,
   output logic [11:0]          x,
   output logic [11:0]          y,
   output logic                 active,
   output logic                 frame_start,
   output logic                 vga_hsync,
   output logic                 vga_vsync,
   output logic [RGB_WIDTH-1:0] vga_r,
   output logic [RGB_WIDTH-1:0] vga_g,
   output logic [RGB_WIDTH-1:0] vga_b
);

   localparam logic [11:0] H_VIS        = 12'(H_ACTIVE);
   localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST       = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] V_VIS        = 12'(V_ACTIVE);
   localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST       = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic        h_wrap;
   logic        v_wrap;
   logic        h_vis;
   logic        v_vis;
   logic        hsync_win;
   logic        vsync_win;

   always_comb begin
      h_wrap    = (h_cnt == H_LAST);
      v_wrap    = (v_cnt == V_LAST);
      h_vis     = (h_cnt < H_VIS);
      v_vis     = (v_cnt < V_VIS);
      hsync_win = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
      vsync_win = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
   end

   // The line counter only advances on the pixel counter's wrap edge.
   always_ff @(posedge CLOCK_25) begin
      if (reset) begin
         h_cnt <= 12'd0;
         v_cnt <= 12'd0;
      end else if (h_wrap) begin
         h_cnt <= 12'd0;
         v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   // Coordinates are 1-based so border tests at 1 and H_ACTIVE/V_ACTIVE hit visible pixels.
   assign x           = h_vis ? h_cnt + 12'd1 : 12'd0;
   assign y           = v_vis ? v_cnt + 12'd1 : 12'd0;
   assign active      = h_vis && v_vis;
   assign frame_start = (h_cnt == 12'd0) && (v_cnt == 12'd0) && !reset;

   always_ff @(posedge CLOCK_25) begin
      if (reset) begin
         vga_hsync <= ~SYNC_ACTIVE;
         vga_vsync <= ~SYNC_ACTIVE;
         vga_r     <= '0;
         vga_g     <= '0;
         vga_b     <= '0;
      end else begin
         vga_hsync <= hsync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vga_vsync <= vsync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vga_r     <= active ? {RGB_WIDTH{color[2]}} : '0;
         vga_g     <= active ? {RGB_WIDTH{color[1]}} : '0;
         vga_b     <= active ? {RGB_WIDTH{color[0]}} : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: a full-size instance for reset, line timing and colour path; a shrunken
// instance (40x20 raster, 800-clock frame) for frame, vsync and mid-frame reset behaviour.
module tb_vga_timing_generator;

   logic        clk = 1'b0;
   logic        rst_a;
   logic        rst_b;
   logic        mode_a;
   logic [2:0]  color_a;
   logic [2:0]  color_b;
   logic [11:0] x_a, y_a, x_b, y_b;
   logic        active_a, fs_a, hs_a, vs_a;
   logic        active_b, fs_b, hs_b, vs_b;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Stand-in image generator: white, or green at x==1 and red elsewhere.
   always_comb begin
      color_a = 3'b111;
      if (mode_a) color_a = (x_a == 12'd1) ? 3'b010 : 3'b100;
   end
   assign color_b = 3'b111;

   vga_timing_generator dut_a (
      .CLOCK_25(clk), .reset(rst_a), .color(color_a), .x(x_a), .y(y_a),
      .active(active_a), .frame_start(fs_a), .vga_hsync(hs_a), .vga_vsync(vs_a),
      .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
   );

   vga_timing_generator #(
      .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(10),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4)
   ) dut_b (
      .CLOCK_25(clk), .reset(rst_b), .color(color_b), .x(x_b), .y(y_b),
      .active(active_b), .frame_start(fs_b), .vga_hsync(hs_b), .vga_vsync(vs_b),
      .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Runs n cycles of the small raster from counter position (0,0), checking every output.
   task automatic run_b(input int n, input int vs_low_exp, input int fs_cnt_exp);
      int h, v, hp, vp, last_fs, fs_cnt, vs_low, max_x, max_y;
      logic       eh, ev;
      logic [3:0] ec;
      last_fs = -1; fs_cnt = 0; vs_low = 0; max_x = 0; max_y = 0;
      for (int c = 0; c < n; c++) begin
         h = c % 40;
         v = (c / 40) % 20;
         #4;
         check("b_x", x_b, (h < 20) ? h + 1 : 0);
         check("b_y", y_b, (v < 12) ? v + 1 : 0);
         check("b_active", active_b, (h < 20 && v < 12) ? 1 : 0);
         check("b_frame_start", fs_b, (h == 0 && v == 0) ? 1 : 0);
         if (c == 0) begin
            eh = 1'b1; ev = 1'b1; ec = 4'h0;
         end else begin
            hp = (c - 1) % 40;
            vp = ((c - 1) / 40) % 20;
            eh = (hp >= 24 && hp < 30) ? 1'b0 : 1'b1;
            ev = (vp >= 14 && vp < 16) ? 1'b0 : 1'b1;
            ec = (hp < 20 && vp < 12) ? 4'hF : 4'h0;
         end
         check("b_hsync", hs_b, eh);
         check("b_vsync", vs_b, ev);
         check("b_r", r_b, ec);
         check("b_g", g_b, ec);
         check("b_b", b_b, ec);
         if (fs_b === 1'b1) begin
            if (last_fs >= 0) check("b_frame_period", c - last_fs, 800);
            last_fs = c;
            fs_cnt++;
         end
         if (vs_b === 1'b0) vs_low++;
         if (int'(x_b) > max_x) max_x = int'(x_b);
         if (int'(y_b) > max_y) max_y = int'(y_b);
         step;
      end
      check("b_frame_start_count", fs_cnt, fs_cnt_exp);
      check("b_vsync_low_clocks", vs_low, vs_low_exp);
      check("b_x_max", max_x, 20);
      check("b_y_max", max_y, 12);
   endtask

   initial begin
      int         h, v, hp, lp, r_on, r_first, hs_low, hs_first;
      logic       eh;
      logic [3:0] er, eg, eb;
      rst_a = 1'b1; rst_b = 1'b1; mode_a = 1'b0;

      repeat (5) begin
         step;
         #4;
         check("rst_hsync", hs_a, 1);
         check("rst_vsync", vs_a, 1);
         check("rst_rgb", {r_a, g_a, b_a}, 0);
         check("rst_frame_start", fs_a, 0);
         check("rst_x", x_a, 1);
         check("rst_y", y_a, 1);
         check("rst_active", active_a, 1);
      end

      step;
      rst_a = 1'b0;
      r_on = 0; r_first = -1; hs_low = 0; hs_first = -1;
      for (int c = 0; c < 1602; c++) begin
         h = c % 800;
         v = c / 800;
         mode_a = (c >= 800);
         #4;
         check("a_x", x_a, (h < 640) ? h + 1 : 0);
         check("a_y", y_a, v + 1);
         check("a_active", active_a, (h < 640) ? 1 : 0);
         check("a_frame_start", fs_a, (c == 0) ? 1 : 0);
         eh = 1'b1; er = 4'h0; eg = 4'h0; eb = 4'h0;
         if (c > 0) begin
            hp = (c - 1) % 800;
            lp = (c - 1) / 800;
            eh = (hp >= 656 && hp < 752) ? 1'b0 : 1'b1;
            if (hp < 640) begin
               if (lp == 0) begin
                  er = 4'hF; eg = 4'hF; eb = 4'hF;
               end else if (hp == 0) begin
                  eg = 4'hF;
               end else begin
                  er = 4'hF;
               end
            end
         end
         check("a_hsync", hs_a, eh);
         check("a_vsync", vs_a, 1);
         check("a_r", r_a, er);
         check("a_g", g_a, eg);
         check("a_b", b_a, eb);
         if (c <= 800) begin
            if (r_a === 4'hF) begin
               if (r_first < 0) r_first = c;
               r_on++;
            end
            if (hs_a === 1'b0) begin
               if (hs_first < 0) hs_first = c;
               hs_low++;
            end
         end
         step;
      end
      check("a_rgb_on_clocks", r_on, 640);
      check("a_rgb_first_clock", r_first, 1);
      check("a_hsync_low_clocks", hs_low, 96);
      check("a_hsync_first_clock", hs_first, 657);

      rst_b = 1'b0;
      run_b(1600, 160, 2);

      // Walk to pixel 26 of line 14, inside both sync windows, then pulse reset.
      repeat (14 * 40 + 26) step;
      #4;
      check("b_mid_x", x_b, 0);
      check("b_mid_hsync", hs_b, 0);
      check("b_mid_vsync", vs_b, 0);
      rst_b = 1'b1;
      step;
      rst_b = 1'b0;
      run_b(801, 80, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Drives the VGA raster for the Pong display at 640x480 @ 60 Hz from the 25 MHz pixel clock.
- Produces the pixel coordinates `x`/`y` consumed by the image generator, and receives that block's 3-bit `color` back.
- Emits registered, mutually aligned hsync/vsync/RGB to the DAC/connector pins.
- Sole source of raster timing; the image generator is purely a function of `x`/`y` plus game state.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low, VGA standard)
- RGB_WIDTH, 4, bits per colour channel at the pins

Ports:
- CLOCK_25  in   1   25 MHz pixel clock; the only clock
- reset     in   1   synchronous, active-high reset
- color     in   3   pixel colour from the image generator for current `x`,`y`; bit2=R, bit1=G, bit0=B
- x         out  12  horizontal coordinate, 1..640 when active, 0 in blanking
- y         out  12  vertical coordinate, 1..480 when active line, 0 otherwise
- active    out  1   1 while current counter position is in the visible area
- frame_start out 1  one-cycle pulse at counter position (0,0)
- vga_hsync out  1   horizontal sync, registered
- vga_vsync out  1   vertical sync, registered
- vga_r     out  RGB_WIDTH  red, registered
- vga_g     out  RGB_WIDTH  green, registered
- vga_b     out  RGB_WIDTH  blue, registered

Behaviour:
- The block has one clock, `CLOCK_25`; `reset` is synchronous and active-high.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
  - `h_cnt` increments every clock and wraps H_TOTAL-1 -> 0.
  - `v_cnt` increments only on the `h_cnt` wrap, and wraps V_TOTAL-1 -> 0 on that same edge.
  - Frame period is 420000 clocks.
- Counter widths: 12 bits. No overflow is possible; comparisons are unsigned.
- Decode (combinational from counter registers, same cycle):
  - `active` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - `x` = h_cnt+1 when h_cnt < H_ACTIVE, else 0.
  - `y` = v_cnt+1 when v_cnt < V_ACTIVE, else 0.
  - Coordinates are 1-based so the image generator's border at x==1/640, y==1/480 lands on the first and last visible pixels.
  - `frame_start` = (h_cnt==0 && v_cnt==0 && !reset).
- Sync windows:
  - hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), over whole lines.
- Output stage (registered, 1-clock latency from counter position):
  - Sync outputs: `vga_hsync`/`vga_vsync` <= SYNC_ACTIVE when in window, else ~SYNC_ACTIVE.
  - Colour, visible: each channel <= {RGB_WIDTH{color[bit]}} when `active`.
  - Colour, blanking: all channels <= 0 when !`active`, regardless of `color`.
  - hsync, vsync and RGB share this single stage, so they stay aligned with each other.
- Reset:
  - While `reset` is asserted: h_cnt = v_cnt = 0; `vga_hsync` = `vga_vsync` = ~SYNC_ACTIVE; RGB = 0; `frame_start` = 0.
  - The combinational outputs follow the counters at (0,0): `x`=1, `y`=1, `active`=1.
  - Reset mid-frame aborts the frame immediately: counters return to (0,0) on the next edge.
  - On the first clock after `reset` deasserts, `frame_start`=1 and counting starts from (0,0).
- `color` is sampled only when `active`. The image generator must present it combinationally in the same cycle as `x`/`y`.

Test Plan:
- Reset held 5 clocks, then released -> during reset hsync=vsync=1, RGB=0, frame_start=0; the first cycle after release has x=1, y=1, active=1, frame_start=1.
- Free-run one line with `color`=3'b111 -> vga_r/g/b=4'hF for exactly 640 consecutive clocks, starting 1 clock after release; RGB=0 during blanking; hsync low for exactly 96 clocks starting 657 clocks after release; line period 800.
- Free-run 2 frames -> frame_start pulses exactly 420000 clocks apart; vsync low for exactly 1600 clocks (2 lines) per frame, beginning at line 490; x never exceeds 640 and y never exceeds 480.
- Drive `color`=3'b010 at x==1 and 3'b100 elsewhere -> on the next clock, first visible pixel vga_g=4'hF with r=b=0, following pixels vga_r=4'hF only.
- Drive `color`=3'b111 constantly, check blanking -> x=0 for h_cnt 640..799 and y=0 for lines 480..524; RGB=0 throughout blanking.
- Assert reset for 1 clock at h_cnt=300, v_cnt=200 -> next cycle counters at (0,0), syncs deasserted, RGB=0; a full 420000-clock frame follows with correct timing.
